if_fetch_unit: RTL and testbench

//  Instruction-fetch stage feeding the IF/ID pipeline register. Holds the PC and issues single-outstanding

---
 rtl/if_fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID pipeline register.
// Holds the PC, keeps at most one instruction-memory request outstanding, and
// presents the fetched word together with PC+PC_STEP. Taken branches redirect
// the fetch. A stale response still in flight is dropped.
// Optional feature: define IF_FETCH_CNT_EN to add the fetch_count output,
// which counts accepted (non-flushed) instructions.
module if_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Freeze,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        inst_valid
`ifdef IF_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    // The counter must be able to hold WAIT_TIMEOUT, so TMO_LAST+1 never overflows.
    localparam int unsigned    TMO_W    = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP,
        S_HOLD
    } state_t;

    state_t             r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic               r_valid;
    logic [TMO_W-1:0]   r_tmo;

    state_t             w_state_nxt;
    logic [31:0]        w_pc_nxt;
    logic [31:0]        w_instr_nxt;
    logic               w_valid_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic               w_timeout;
    logic               w_accept;

    // The count carries on from WAIT into DROP because it is the same request in flight.
    // A WAIT->DROP move on the last count can land one step past TMO_LAST, hence >=.
    assign w_timeout = (r_tmo >= TMO_LAST);

    // An instruction leaves HOLD into the pipeline only when neither redirected nor frozen.
    assign w_accept = (r_state == S_HOLD) && !Branch_taken && !Freeze;

    // Next-state and datapath update for the fetch FSM.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
        w_tmo_nxt   = r_tmo;

        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end

            S_REQ: begin
                w_state_nxt = S_WAIT;
                w_tmo_nxt   = '0;
            end

            S_WAIT: begin
                w_tmo_nxt = r_tmo + TMO_W'(1);
                if (Branch_taken) begin
                    // The request now targets the wrong address. A response
                    // arriving this same cycle can be thrown away at once.
                    // Otherwise it must still be waited out in DROP.
                    w_pc_nxt    = Branch_addr;
                    w_state_nxt = imem_valid ? S_REQ : S_DROP;
                end else if (imem_valid) begin
                    w_instr_nxt = imem_rdata;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (w_timeout) begin
                    w_state_nxt = S_REQ;
                end
            end

            S_DROP: begin
                w_tmo_nxt = r_tmo + TMO_W'(1);
                if (Branch_taken) begin
                    w_pc_nxt = Branch_addr;
                end
                if (imem_valid || w_timeout) begin
                    w_state_nxt = S_REQ;
                end
            end

            S_HOLD: begin
                if (Branch_taken) begin
                    // A redirect flushes the held word even while frozen.
                    w_pc_nxt    = Branch_addr;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_REQ;
                end else if (!Freeze) begin
                    w_pc_nxt    = r_pc + PC_STEP;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_VECTOR;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

`ifdef IF_FETCH_CNT_EN
    logic [31:0] r_fetch_count;

    // Count instructions handed to IF/ID. Words flushed by a branch are not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_accept) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

    // The request address is only meaningful while the strobe is up, so it idles at zero.
    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = imem_req ? r_pc : 32'h0;
    assign PC          = r_pc + PC_STEP;
    assign inst_valid  = r_valid;
    assign Instruction = r_valid ? r_instr : 32'h0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit.
// A scoreboard holds the expected request addresses and the expected
// (Instruction, PC) pairs. Entries are pushed as stimulus is set up and are
// popped when the DUT raises imem_req or inst_valid. The bench has a
// 1-cycle memory that can be switched off so scenarios can drive
// imem_valid by hand.
module tb_if_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        Freeze;
    logic        Branch_taken;
    logic [31:0] Branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        inst_valid;
`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_count;
`endif

    logic [31:0] addr_q[$];
    exp_t        inst_q[$];

    int          n_vec = 0;
    int          n_err = 0;
    bit          mem_auto;
    bit          pend_req;
    logic [31:0] pend_addr;
    bit          prev_valid;

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .Freeze       (Freeze),
        .Branch_taken (Branch_taken),
        .Branch_addr  (Branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .PC           (PC),
        .Instruction  (Instruction),
        .inst_valid   (inst_valid)
`ifdef IF_FETCH_CNT_EN
        ,
        .fetch_count  (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_inst(input logic [31:0] instr, input logic [31:0] pc);
        exp_t e;
        e.instr = instr;
        e.pc    = pc;
        inst_q.push_back(e);
    endtask

    // Advance one cycle, then run the memory model and the scoreboard 1ns after the edge.
    task automatic tick();
        exp_t        e;
        logic [31:0] a;
        @(posedge clk);
        #1;
        if (mem_auto) begin
            imem_valid = pend_req;
            imem_rdata = pend_addr;
        end
        pend_req  = (imem_req === 1'b1);
        pend_addr = imem_addr;
        if (imem_req === 1'b1) begin
            check("req_expected", 32'(addr_q.size() != 0), 32'd1);
            if (addr_q.size() != 0) begin
                a = addr_q.pop_front();
                check("imem_addr", imem_addr, a);
            end
        end
        if (inst_valid === 1'b1 && !prev_valid) begin
            check("inst_expected", 32'(inst_q.size() != 0), 32'd1);
            if (inst_q.size() != 0) begin
                e = inst_q.pop_front();
                check("instruction", Instruction, e.instr);
                check("pc_out", PC, e.pc);
            end
        end
        if (inst_valid === 1'b0) begin
            check("bubble", Instruction, 32'h0);
        end
        prev_valid = (inst_valid === 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nv;
        int n;
        rst          = 1'b1;
        Freeze       = 1'b0;
        Branch_taken = 1'b0;
        Branch_addr  = 32'h0;
        imem_valid   = 1'b0;
        imem_rdata   = 32'h0;
        mem_auto     = 1'b0;
        pend_req     = 1'b0;
        pend_addr    = 32'h0;
        prev_valid   = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_instr", Instruction, 32'h0);
        check("rst_pc",    PC, 32'h4);
`ifdef IF_FETCH_CNT_EN
        check("rst_count", fetch_count, 32'd0);
`endif

        // Streaming fetch with the memory returning the address as data.
        rst      = 1'b0;
        mem_auto = 1'b1;
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h4);
        addr_q.push_back(32'h8);
        expect_inst(32'h0, 32'h4);
        expect_inst(32'h4, 32'h8);
        expect_inst(32'h8, 32'hC);
        nv = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (inst_valid === 1'b1) nv++;
        end
        check("valid_duty", nv, 3);

        // Freeze for 3 cycles in HOLD at pc_q=8.
        Freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_instr", Instruction, 32'h8);
            check("frz_pc",    PC, 32'hC);
            check("frz_valid", 32'(inst_valid), 32'd1);
            check("frz_req",   32'(imem_req), 32'd0);
        end
        Freeze = 1'b0;
        addr_q.push_back(32'hC);
        tick();
        check("unfrz_req", 32'(imem_req), 32'd1);
        expect_inst(32'hC, 32'h10);
        tick();
        tick();
`ifdef IF_FETCH_CNT_EN
        check("count_after_3", fetch_count, 32'd3);
`endif

        // Branch in WAIT, stale response arrives 2 cycles after the request.
        mem_auto = 1'b0;
        addr_q.push_back(32'h10);
        tick();
        tick();
        Branch_taken = 1'b1;
        Branch_addr  = 32'h100;
        tick();
        Branch_taken = 1'b0;
        check("drop_valid", 32'(inst_valid), 32'd0);
        check("drop_req",   32'(imem_req), 32'd0);
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        addr_q.push_back(32'h100);
        tick();
        check("drop_reissue", 32'(imem_req), 32'd1);
        check("drop_valid2",  32'(inst_valid), 32'd0);
        imem_valid = 1'b0;
        mem_auto   = 1'b1;
        expect_inst(32'h100, 32'h104);
        tick();
        tick();
        check("br_hold_valid", 32'(inst_valid), 32'd1);

        // Branch together with a response in the same WAIT cycle.
        mem_auto = 1'b0;
        addr_q.push_back(32'h104);
        tick();
        tick();
        imem_valid   = 1'b1;
        imem_rdata   = 32'h0BAD_0BAD;
        Branch_taken = 1'b1;
        Branch_addr  = 32'h200;
        addr_q.push_back(32'h200);
        tick();
        check("brv_req",   32'(imem_req), 32'd1);
        check("brv_valid", 32'(inst_valid), 32'd0);
        Branch_taken = 1'b0;
        imem_valid   = 1'b0;
        mem_auto     = 1'b1;
        expect_inst(32'h200, 32'h204);
        tick();
        tick();

        // Branch overrides Freeze in HOLD, then the request to 0x20 times out.
        Branch_taken = 1'b1;
        Branch_addr  = 32'h20;
        Freeze       = 1'b1;
        mem_auto     = 1'b0;
        addr_q.push_back(32'h20);
        tick();
        check("br_over_frz", 32'(imem_req), 32'd1);
        Branch_taken = 1'b0;
        Freeze       = 1'b0;
        addr_q.push_back(32'h20);
        n = 0;
        do begin
            tick();
            n++;
        end while (imem_req !== 1'b1 && n < 400);
        check("tmo_cycles", n, 256);
        mem_auto = 1'b1;
        expect_inst(32'h20, 32'h24);
        tick();
        tick();

        // PC wrap at the top of the address space.
        Branch_taken = 1'b1;
        Branch_addr  = 32'hFFFF_FFFC;
        addr_q.push_back(32'hFFFF_FFFC);
        tick();
        Branch_taken = 1'b0;
        expect_inst(32'hFFFF_FFFC, 32'h0);
        tick();
        tick();
        check("wrap_pc", PC, 32'h0);
        addr_q.push_back(32'h0);
        tick();

        // Reset during WAIT, then a late response arrives in IDLE.
        mem_auto = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        imem_valid = 1'b1;
        imem_rdata = 32'h5555_5555;
        check("rst2_req",   32'(imem_req), 32'd0);
        check("rst2_addr",  imem_addr, 32'h0);
        check("rst2_valid", 32'(inst_valid), 32'd0);
        check("rst2_pc",    PC, 32'h4);
`ifdef IF_FETCH_CNT_EN
        check("rst2_count", fetch_count, 32'd0);
`endif
        addr_q.push_back(32'h0);
        tick();
        check("late_ignored", 32'(inst_valid), 32'd0);
        imem_valid = 1'b0;
        mem_auto   = 1'b1;
        expect_inst(32'h0, 32'h4);
        tick();
        tick();
        check("final_valid", 32'(inst_valid), 32'd1);

        check("addr_q_left", 32'(addr_q.size()), 32'd0);
        check("inst_q_left", 32'(inst_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
